// File: rtl/pulse_stretch_arbiter.sv
// pulse_stretch_arbiter
// Round-robin arbiter for NUM_REQ edge-triggered requesters sharing one
// stretched output pulse. Every grant drives hold_out high for a latched
// number of cycles, optionally followed by a forced-low gap. Requests that
// arrive while the pulse is busy are queued one deep per channel. A second
// request on a channel that is already queued is reported on drop_pulse.
module pulse_stretch_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int COUNT_BW = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_in,
    input  logic [COUNT_BW-1:0] cfg_hold_cycles,
    input  logic [COUNT_BW-1:0] cfg_gap_cycles,
    output logic                hold_out,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic [NUM_REQ-1:0]  pending,
    output logic [NUM_REQ-1:0]  drop_pulse,
    output logic                busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Registered state
    logic [1:0]          state_q,    state_d;
    logic [NUM_REQ-1:0]  req_dly_q;
    logic [NUM_REQ-1:0]  pend_q,     pend_d;
    logic [NUM_REQ-1:0]  drop_q,     drop_d;
    logic [NUM_REQ-1:0]  grant_q,    grant_d;
    logic                hold_q,     hold_d;
    logic [COUNT_BW-1:0] cnt_q,      cnt_d;
    logic [PTR_W-1:0]    rr_q,       rr_d;
    logic [COUNT_BW-1:0] hold_len_q, hold_len_d;
    logic [COUNT_BW-1:0] gap_len_q,  gap_len_d;

    // Combinational helpers
    logic [NUM_REQ-1:0]  rise;
    logic [NUM_REQ-1:0]  cand;
    logic                sel_vld;
    logic [PTR_W-1:0]    sel_idx;
    logic                grant_now;
    logic [NUM_REQ-1:0]  grant_vec;
    logic [COUNT_BW-1:0] hold_len_cfg;
    logic [PTR_W-1:0]    rr_after_sel;

    // A zero hold length would produce no pulse at all, so it is promoted to one.
    assign hold_len_cfg = (cfg_hold_cycles == '0) ? COUNT_BW'(1) : cfg_hold_cycles;

    assign rise = req_in & ~req_dly_q;
    assign cand = pend_q | rise;

    // Round-robin search: first candidate at or above rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!sel_vld && cand[idx]) begin
                sel_vld = 1'b1;
                sel_idx = PTR_W'(idx);
            end
        end
    end

    // A grant is only issued from IDLE; that IDLE cycle is the mandatory low cycle.
    assign grant_now = (state_q == ST_IDLE) && sel_vld;
    assign grant_vec = grant_now ? (NUM_REQ'(1) << sel_idx) : '0;

    assign rr_after_sel = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (sel_idx + PTR_W'(1));

    // Queue bookkeeping: a granted channel keeps its queued bit only when a fresh
    // rise coincides with the grant; a rise on an already-queued, ungranted channel
    // is lost and flagged.
    always_comb begin
        pend_d = ((pend_q | rise) & ~grant_vec) | (grant_vec & pend_q & rise);
        drop_d = rise & pend_q & ~grant_vec;
    end

    // Pulse/gap sequencer: IDLE arbitrates, HOLD stretches, GAP forces low.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        hold_len_d = hold_len_q;
        gap_len_d  = gap_len_q;
        case (state_q)
            ST_IDLE: begin
                hold_d  = 1'b0;
                grant_d = '0;
                cnt_d   = '0;
                if (sel_vld) begin
                    // Lengths are captured here so later cfg changes cannot
                    // disturb the pulse or gap that follows.
                    state_d    = ST_HOLD;
                    grant_d    = grant_vec;
                    hold_d     = 1'b1;
                    hold_len_d = hold_len_cfg;
                    gap_len_d  = cfg_gap_cycles;
                    rr_d       = rr_after_sel;
                end
            end
            ST_HOLD: begin
                if (cnt_q == hold_len_q - COUNT_BW'(1)) begin
                    cnt_d   = '0;
                    hold_d  = 1'b0;
                    grant_d = '0;
                    state_d = (gap_len_q != '0) ? ST_GAP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + COUNT_BW'(1);
                end
            end
            ST_GAP: begin
                hold_d  = 1'b0;
                grant_d = '0;
                if (cnt_q == gap_len_q - COUNT_BW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + COUNT_BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State update with synchronous reset; reset discards queued requests silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_dly_q  <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            grant_q    <= '0;
            hold_q     <= 1'b0;
            cnt_q      <= '0;
            rr_q       <= '0;
            hold_len_q <= COUNT_BW'(1);
            gap_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_dly_q  <= req_in;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            grant_q    <= grant_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            hold_len_q <= hold_len_d;
            gap_len_q  <= gap_len_d;
        end
    end

    assign hold_out     = hold_q;
    assign grant_onehot = grant_q;
    assign pending      = pend_q;
    assign drop_pulse   = drop_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// tb_pulse_stretch_arbiter
// Directed scenarios plus randomized traffic for pulse_stretch_arbiter, with a
// countdown-based reference model compared against the DUT on every cycle.
module tb_pulse_stretch_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req_in;
    logic [9:0] cfg_hold_cycles;
    logic [9:0] cfg_gap_cycles;
    logic       hold_out;
    logic [3:0] grant_onehot;
    logic [3:0] pending;
    logic [3:0] drop_pulse;
    logic       busy;

    int n_chk;
    int n_fail;

    pulse_stretch_arbiter #(.NUM_REQ(4), .COUNT_BW(10)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_in          (req_in),
        .cfg_hold_cycles (cfg_hold_cycles),
        .cfg_gap_cycles  (cfg_gap_cycles),
        .hold_out        (hold_out),
        .grant_onehot    (grant_onehot),
        .pending         (pending),
        .drop_pulse      (drop_pulse),
        .busy            (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase 0 idle, 1 pulse, 2 gap; m_left counts down
    // the remaining cycles of the current phase.
    // ------------------------------------------------------------------
    int         m_phase;
    int         m_left;
    int         m_gaplen;
    int         m_rr;
    logic [3:0] m_prev;
    logic [3:0] m_pend;
    logic [3:0] m_drop;
    logic [3:0] m_grant;
    logic       m_hold;

    task automatic model_step();
        logic [3:0] rise;
        logic [3:0] cand;
        logic [3:0] gvec;
        logic [3:0] old_pend;
        int         sel;
        if (reset) begin
            m_phase = 0; m_left = 0; m_gaplen = 0; m_rr = 0;
            m_prev = '0; m_pend = '0; m_drop = '0; m_grant = '0; m_hold = 1'b0;
            return;
        end
        rise   = req_in & ~m_prev;
        m_prev = req_in;
        gvec   = '0;
        if (m_phase == 0) begin
            cand = m_pend | rise;
            if (cand != 0) begin
                sel = -1;
                for (int k = 0; k < 4; k++) begin
                    if (sel < 0 && cand[(m_rr + k) % 4]) sel = (m_rr + k) % 4;
                end
                gvec     = 4'(1 << sel);
                m_grant  = gvec;
                m_hold   = 1'b1;
                m_left   = (cfg_hold_cycles == 0) ? 1 : int'(cfg_hold_cycles);
                m_gaplen = int'(cfg_gap_cycles);
                m_rr     = (sel + 1) % 4;
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_hold  = 1'b0;
                m_grant = '0;
                if (m_gaplen != 0) begin
                    m_phase = 2;
                    m_left  = m_gaplen;
                end else begin
                    m_phase = 0;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
        old_pend = m_pend;
        for (int i = 0; i < 4; i++) begin
            if (gvec[i]) m_pend[i] = old_pend[i] & rise[i];
            else         m_pend[i] = old_pend[i] | rise[i];
            m_drop[i] = rise[i] & old_pend[i] & ~gvec[i];
        end
    endtask

    initial begin
        m_phase = 0; m_left = 0; m_gaplen = 0; m_rr = 0;
        m_prev = '0; m_pend = '0; m_drop = '0; m_grant = '0; m_hold = 1'b0;
        forever begin
            @(posedge clock);
            model_step();
            #1;
            chk("model_hold_out", hold_out, m_hold);
            chk("model_grant", grant_onehot, m_grant);
            chk("model_pending", pending, m_pend);
            chk("model_drop", drop_pulse, m_drop);
            chk("model_busy", busy, (m_phase != 0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name, input logic [3:0] exp);
        int n;
        n = 0;
        while (hold_out && n < 60) begin tick(); n++; end
        while (!hold_out && n < 60) begin tick(); n++; end
        if (n >= 60) timeout_fail(name);
        else chk(name, grant_onehot, exp);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || hold_out) && n < 60) begin tick(); n++; end
        if (n >= 60) timeout_fail(name);
    endtask

    initial begin
        logic [3:0] seq [6];
        logic [3:0] exp_seq [6];
        logic       prev_h;
        int         ng;
        int         cnt3;
        int         len;

        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        req_in = '0;
        cfg_hold_cycles = '0;
        cfg_gap_cycles = '0;
        tick();
        tick();
        chk("reset_hold", hold_out, 0);
        chk("reset_grant", grant_onehot, 0);
        chk("reset_pending", pending, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Single request: hold 5, gap 2
        cfg_hold_cycles = 10'd5;
        cfg_gap_cycles  = 10'd2;
        req_in = 4'b0010;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("single_hold", hold_out, 1);
            chk("single_grant", grant_onehot, 4'b0010);
            if (k < 4) tick();
        end
        tick();
        chk("single_gap1_low", hold_out, 0);
        chk("single_gap1_busy", busy, 1);
        tick();
        chk("single_gap2_low", hold_out, 0);
        chk("single_gap2_busy", busy, 1);
        tick();
        chk("single_idle_busy", busy, 0);
        req_in = '0;
        tick();

        // Simultaneous requests from rr_ptr = 0
        do_reset();
        cfg_hold_cycles = 10'd2;
        cfg_gap_cycles  = 10'd1;
        req_in = 4'b0101;
        tick();
        chk("simul_first", grant_onehot, 4'b0001);
        chk("simul_pending", pending, 4'b0100);
        wait_grant("simul_second", 4'b0100);
        req_in = '0;
        wait_idle("simul_idle");
        tick();
        req_in = 4'b1001;
        tick();
        chk("simul_rr_ptr3", grant_onehot, 4'b1000);
        req_in = '0;
        wait_idle("simul_idle2");

        // Fairness with continuous re-requests
        do_reset();
        cfg_hold_cycles = 10'd1;
        cfg_gap_cycles  = 10'd0;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 6; i++) seq[i] = '0;
        ng = 0;
        prev_h = 1'b0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            req_in = c[0] ? 4'hF : 4'h0;
            tick();
            if (hold_out && !prev_h) begin
                seq[ng] = grant_onehot;
                ng++;
            end
            prev_h = hold_out;
        end
        chk("fair_count", ng, 6);
        for (int i = 0; i < 6; i++) chk("fair_order", seq[i], exp_seq[i]);
        req_in = '0;
        wait_idle("fair_idle");

        // Drop on a second rise while queued
        do_reset();
        cfg_hold_cycles = 10'd6;
        cfg_gap_cycles  = 10'd0;
        req_in = 4'b0001;
        tick();
        chk("drop_first_grant", grant_onehot, 4'b0001);
        req_in = 4'b1001;
        tick();
        chk("drop_queued", pending, 4'b1000);
        chk("drop_none_yet", drop_pulse, 4'b0000);
        req_in = 4'b0001;
        tick();
        req_in = 4'b1001;
        tick();
        chk("drop_flag", drop_pulse, 4'b1000);
        chk("drop_pending_kept", pending, 4'b1000);
        req_in = 4'b0001;
        tick();
        chk("drop_one_cycle", drop_pulse, 4'b0000);
        cnt3 = 0;
        prev_h = hold_out;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (hold_out && !prev_h && grant_onehot == 4'b1000) cnt3++;
            prev_h = hold_out;
        end
        chk("drop_single_grant3", cnt3, 1);
        req_in = '0;
        wait_idle("drop_idle");

        // Boundaries: hold=0, gap=0
        do_reset();
        cfg_hold_cycles = 10'd0;
        cfg_gap_cycles  = 10'd0;
        req_in = 4'b0011;
        tick();
        chk("bnd_grant0", grant_onehot, 4'b0001);
        chk("bnd_hold0", hold_out, 1);
        chk("bnd_pending", pending, 4'b0010);
        tick();
        chk("bnd_low", hold_out, 0);
        chk("bnd_low_busy", busy, 0);
        tick();
        chk("bnd_grant1", grant_onehot, 4'b0010);
        chk("bnd_hold1", hold_out, 1);
        tick();
        chk("bnd_end", hold_out, 0);

        // cfg changed mid-pulse must not alter the current pulse
        req_in = '0;
        tick();
        cfg_hold_cycles = 10'd4;
        req_in = 4'b0100;
        tick();
        chk("cfgchg_grant", grant_onehot, 4'b0100);
        cfg_hold_cycles = 10'd1;
        cfg_gap_cycles  = 10'd3;
        len = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!hold_out) break;
            len++;
        end
        chk("cfgchg_len", len, 4);
        req_in = '0;
        wait_idle("cfgchg_idle");

        // Mid-operation reset with queued requests
        do_reset();
        cfg_hold_cycles = 10'd8;
        cfg_gap_cycles  = 10'd0;
        req_in = 4'b0001;
        tick();
        req_in = 4'b1011;
        tick();
        chk("rst_pending_before", pending, 4'b1010);
        reset = 1'b1;
        req_in = 4'b0001;
        tick();
        chk("rst_hold", hold_out, 0);
        chk("rst_grant", grant_onehot, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_pulse, 0);
        reset = 1'b0;
        tick();
        chk("rst_release_hold", hold_out, 1);
        chk("rst_release_grant", grant_onehot, 4'b0001);

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) req_in[i] = ~req_in[i];
            end
            if ($urandom_range(0, 19) == 0) begin
                cfg_hold_cycles = 10'($urandom_range(0, 4));
                cfg_gap_cycles  = 10'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        req_in = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_arbiter.md
PULSE_STRETCH_ARBITER -- requirements
Module: pulse_stretch_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 4, number of requesters.
- COUNT_BW, 10, width of the hold and gap counters and config fields.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_in  in  NUM_REQ  level request lines; rising edge = one request.
- cfg_hold_cycles  in  COUNT_BW  stretched-pulse length in cycles.
- cfg_gap_cycles  in  COUNT_BW  forced-low cycles after each pulse.
- hold_out  out  1  shared stretched pulse.
- grant_onehot  out  NUM_REQ  owner of the current pulse.
- pending  out  NUM_REQ  queued, ungranted requests.
- drop_pulse  out  NUM_REQ  1-cycle flag: request lost.
- busy  out  1  FSM not in IDLE.

REQ-003 All outputs SHALL be registered, except busy, which is decoded from the state register.

Function
REQ-004 Edge detect: req_dly[i] SHALL register req_in[i]; rise[i] = req_in[i] & ~req_dly[i].
REQ-005 Candidate vector SHALL be cand = pending | rise.
REQ-006 FSM states SHALL be IDLE, HOLD and GAP; any illegal encoding SHALL go to IDLE.
REQ-007 Arbitration in IDLE with cand nonzero:
- Select the first set bit of cand, searching from rr_ptr upward with wrap modulo NUM_REQ.
- On the same edge: state <= HOLD, grant_onehot <= selected bit, hold_out <= 1, counter <= 0.
- On the same edge: latch hold_len = max(cfg_hold_cycles, 1) and gap_len = cfg_gap_cycles.
- On the same edge: rr_ptr <= (selected+1) mod NUM_REQ.
REQ-008 Latency: req_in sampled low then high at consecutive edges t-1, t, with FSM in IDLE and no other candidate, SHALL give hold_out=1 after edge t.
REQ-009 HOLD:
- hold_out=1 and grant_onehot stable; counter increments each cycle.
- At counter == hold_len-1: counter <= 0, hold_out <= 0, grant_onehot <= 0.
- Next state is GAP if gap_len != 0, else IDLE.
- hold_out SHALL be high for exactly hold_len cycles.
REQ-010 GAP: hold_out=0; counter increments; at counter == gap_len-1 the FSM SHALL go to IDLE.
REQ-011 In IDLE, hold_out SHALL stay 0 for at least one cycle between consecutive grants; this is the arbitration cycle.
REQ-012 Changes on cfg_* during HOLD or GAP SHALL NOT affect the current pulse or gap.
REQ-013 pending[i] SHALL set on rise[i] when bit i is not selected that cycle.
REQ-014 pending[i] SHALL clear on the edge where bit i is granted.
REQ-015 If rise[i] occurs on the same edge that grants a pending[i], pending[i] SHALL remain set, so the new request is queued.
REQ-016 If rise[i] occurs while pending[i]=1 and bit i is not granted that edge, drop_pulse[i] SHALL be 1 for one cycle and pending is unchanged.
REQ-017 A rise on the channel currently being granted during HOLD SHALL queue normally and SHALL NOT extend the current pulse.
REQ-018 Counter arithmetic SHALL be COUNT_BW-bit unsigned. cfg_hold_cycles=0 SHALL be treated as 1. cfg_gap_cycles=0 SHALL mean the GAP state is skipped.

Reset
REQ-019 While reset=1 at a posedge, on that edge:
- state <= IDLE.
- hold_out, grant_onehot, pending, drop_pulse, req_dly, counter and rr_ptr <= 0.
- busy = 0.
REQ-020 Reset asserted mid-HOLD or mid-GAP SHALL abort immediately. All queued requests are discarded with no drop_pulse.
REQ-021 Because req_dly resets to 0, a req_in held high through reset release SHALL count as one rise at the first edge after release.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Single request: hold=5, gap=2, req_in[1] rises (edge t) -> hold_out=1 for edges t..t+4 with grant_onehot=4'b0010; low 2 gap cycles; busy=0 from edge t+7.
- Simultaneous requests: req_in[0] and req_in[2] rise together, rr_ptr=0 -> grants 4'b0001 then 4'b0100; pending[2]=1 during the first pulse; final rr_ptr=3.
- Fairness: all four channels re-requesting continuously -> grant order 0,1,2,3,0,1; no channel skipped.
- Drop: req_in[3] rises twice while pending[3]=1 during another channel's HOLD -> drop_pulse[3]=1 for one cycle; exactly one grant to channel 3.
- Boundaries: hold=0, gap=0 -> 1-cycle pulses separated by exactly one low IDLE cycle. cfg_hold_cycles changed mid-HOLD -> current pulse length unchanged.
- Mid-operation reset: reset asserted mid-HOLD with pending=4'b1010 -> next cycle hold_out=0, grant_onehot=0, pending=0, busy=0. req_in[0] held high across release -> grant 4'b0001 after the first post-reset edge.
